// File: rtl/div_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_arbiter: round-robin front end sharing one unsigned divider    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module div_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ-1:0]      req_sgn,
  output logic [NREQ-1:0]      resp_vld,
  input  logic [NREQ-1:0]      resp_rdy,
  output logic [NREQ*XLEN-1:0] resp_quo,
  output logic [NREQ*XLEN-1:0] resp_rem,
  output logic [XLEN-1:0]      div_a,
  output logic [XLEN-1:0]      div_b,
  output logic                 div_vld,
  input  logic [XLEN-1:0]      div_quo,
  input  logic [XLEN-1:0]      div_rem,
  input  logic                 div_ack,
  output logic                 tag_err
);

  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int T_OV  = XLEN;
  localparam int T_DZ  = XLEN + 1;
  localparam int T_RS  = XLEN + 2;
  localparam int T_QS  = XLEN + 3;
  localparam int T_ID  = XLEN + 4;
  localparam int T_VLD = XLEN + 4 + IDW;
  localparam int TW    = T_VLD + 1;
  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [NREQ-1:0]      busy_q, busy_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]      resp_vld_q, resp_vld_d;
  logic [NREQ*XLEN-1:0] quo_q, quo_d, rem_q, rem_d;
  logic                 tag_err_q, tag_err_d;

  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;

  always_comb begin : p_grant
    int idx;
    idx     = 0;
    elig    = req_vld & ~busy_q;
    req_rdy = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any      = 1'b1;
        gnt_id       = IDW'(idx);
        req_rdy[idx] = 1'b1;
      end
    end
  end

  logic [XLEN-1:0] sel_a, sel_b;
  logic            sel_sgn, neg_a, neg_b, ovf;
  logic [TW-1:0]   tag_in, tag_out;

  assign sel_a   = req_a[int'(gnt_id)*XLEN +: XLEN];
  assign sel_b   = req_b[int'(gnt_id)*XLEN +: XLEN];
  assign sel_sgn = req_sgn[gnt_id];
  assign neg_a   = sel_sgn & sel_a[XLEN-1];
  assign neg_b   = sel_sgn & sel_b[XLEN-1];
  assign ovf     = sel_sgn && (sel_a == C_MIN) && (sel_b == '1);

  assign div_vld = gnt_any;
  assign div_a   = neg_a ? -sel_a : sel_a;
  assign div_b   = neg_b ? -sel_b : sel_b;

  // Everything needed to finish the op travels with it; the divider sees magnitudes only.
  assign tag_in = {gnt_any, gnt_id, neg_a ^ neg_b, neg_a, (sel_b == '0), ovf, sel_a};

  generate
    if (LAT == 0) begin : g_lat0
      assign tag_out = tag_in;
    end else begin : g_pipe
      logic [TW-1:0] tag_q [LAT];
      logic [TW-1:0] tag_d [LAT];
      always_comb begin
        tag_d[0] = tag_in;
        for (int s = 1; s < LAT; s++) tag_d[s] = tag_q[s-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
        end else begin
          for (int s = 0; s < LAT; s++) tag_q[s] <= tag_d[s];
        end
      end
      assign tag_out = tag_q[LAT-1];
    end
  endgenerate

  logic            t_vld, t_qs, t_rs, t_dz, t_ov;
  logic [IDW-1:0]  t_id;
  logic [XLEN-1:0] t_a, fix_quo, fix_rem;

  assign t_vld = tag_out[T_VLD];
  assign t_id  = tag_out[T_ID +: IDW];
  assign t_qs  = tag_out[T_QS];
  assign t_rs  = tag_out[T_RS];
  assign t_dz  = tag_out[T_DZ];
  assign t_ov  = tag_out[T_OV];
  assign t_a   = tag_out[XLEN-1:0];

  always_comb begin
    fix_quo = t_qs ? -div_quo : div_quo;
    fix_rem = t_rs ? -div_rem : div_rem;
    if (t_dz) begin
      fix_quo = '1;
      fix_rem = t_a;
    end else if (t_ov) begin
      fix_quo = t_a;
      fix_rem = '0;
    end
  end

  always_comb begin
    resp_vld_d = resp_vld_q & ~resp_rdy;
    busy_d     = (busy_q | req_rdy) & ~(resp_vld_q & resp_rdy);
    ptr_d      = ptr_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    if (gnt_any) ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
    if (div_ack && t_vld) begin
      resp_vld_d[t_id]               = 1'b1;
      quo_d[int'(t_id)*XLEN +: XLEN] = fix_quo;
      rem_d[int'(t_id)*XLEN +: XLEN] = fix_rem;
    end
    tag_err_d = tag_err_q | (div_ack != t_vld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      ptr_q      <= '0;
      resp_vld_q <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      resp_vld_q <= resp_vld_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      tag_err_q  <= tag_err_d;
    end
  end

  assign resp_vld = resp_vld_q;
  assign resp_quo = quo_q;
  assign resp_rem = rem_q;
  assign tag_err  = tag_err_q;

endmodule
`default_nettype wire
